sdram_port_arbiter: RTL

//  Shares the single SDRAM controller command port between two burst requesters.
//  P0 is the display refill path (read-only, high priority). P1 is the fractal

---
 rtl/sdram_port_arbiter_pkg.sv | 34 +++
 rtl/sdram_port_arbiter_burst_beat_counter.sv | 50 +++++
 rtl/sdram_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Purpose: shared controller command encodings, burst length, bus widths, the
//          arbiter state encoding and the frame-wrapping address step helper.
// Ports:   none (package).
package sdram_port_arbiter_pkg;

  // Controller command encodings (shared with the SDRAM controller).
  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  // The controller is built for fixed-length read bursts; the arbiter's
  // beat counter has to agree with it.
  localparam int READ_BURST_LENGTH = 8;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_WR1  = 2'd3
  } arb_state_t;

  // Advance one word, wrapping only from the last frame word back to 0.
  // Addresses above the frame simply keep incrementing.
  function automatic logic [ADDR_W-1:0] next_beat_addr(
    input logic [ADDR_W-1:0] i_addr,
    input logic [ADDR_W-1:0] i_last
  );
    return (i_addr == i_last) ? '0 : i_addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_burst_beat_counter.sv
// Purpose: per-burst beat counter and word-address stepper with frame wrap.
//          Latency: address/counter update on the edge after load or beat;
//          o_Last is combinational from the counter. No backpressure.
// Ports:   i_Clk, i_Reset (sync, active-high); i_Load + i_Base_Addr start a
//          burst; i_Beat advances one beat; o_Addr current beat address;
//          o_Last high while the counter sits on the final beat.
module sdram_port_arbiter_burst_beat_counter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 96000
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Load,
  input  logic [ADDR_W-1:0] i_Base_Addr,
  input  logic              i_Beat,
  output logic [ADDR_W-1:0] o_Addr,
  output logic              o_Last
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [CNT_W-1:0]  r_Count;
  logic [ADDR_W-1:0] r_Addr;

  // Load and beat are mutually exclusive in practice (load only happens in
  // IDLE, beats only in a burst state); load is given precedence anyway.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Count <= '0;
      r_Addr  <= '0;
    end else if (i_Load) begin
      r_Count <= CNT_LOAD;
      r_Addr  <= i_Base_Addr;
    end else if (i_Beat) begin
      r_Addr <= next_beat_addr(r_Addr, LAST_ADDR);
      // Hold at zero so a stray beat cannot wrap the counter.
      if (r_Count != '0) begin
        r_Count <= r_Count - CNT_W'(1);
      end
    end
  end

  assign o_Addr = r_Addr;
  assign o_Last = (r_Count == '0);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Purpose: shares one SDRAM controller command port between the display
//          refill path (P0, read-only, high priority) and the renderer (P1,
//          read/write). Latency: winner registered one edge after the request
//          is seen in IDLE; beat strobes and Done are routed combinationally.
//          Backpressure: requesters hold Req until granted; beats are paced by
//          the controller strobes.
// Ports:   i_Clk, i_Reset (sync, active-high); P0 Req/Addr -> Grant/Data_Valid/
//          Done; P1 Req/Write/Addr/Data -> Grant/Data_Valid/Data_Next/Done;
//          controller side o_Command/o_Data_Address/o_Data_Write and
//          i_Data_Read_Valid/i_Data_Write_Done; o_Error sticky protocol error.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int BURST_LEN     = READ_BURST_LENGTH,
  parameter int FRAME_WORDS   = 96000,
  parameter int P0_MAX_CONSEC = 4
) (
  input  logic              i_Clk,
  input  logic              i_Reset,

  input  logic              i_P0_Req,
  input  logic [ADDR_W-1:0] i_P0_Addr,
  output logic              o_P0_Grant,
  output logic              o_P0_Data_Valid,
  output logic              o_P0_Done,

  input  logic              i_P1_Req,
  input  logic              i_P1_Write,
  input  logic [ADDR_W-1:0] i_P1_Addr,
  input  logic [DATA_W-1:0] i_P1_Data,
  output logic              o_P1_Grant,
  output logic              o_P1_Data_Valid,
  output logic              o_P1_Data_Next,
  output logic              o_P1_Done,

  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic [DATA_W-1:0] o_Data_Write,
  input  logic              i_Data_Read_Valid,
  input  logic              i_Data_Write_Done,
  output logic              o_Error
);

  localparam int CONSEC_W = (P0_MAX_CONSEC > 0) ? $clog2(P0_MAX_CONSEC + 1) : 1;
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(P0_MAX_CONSEC);

  arb_state_t          r_State;
  logic [1:0]          r_Command;
  logic                r_P0_Grant;
  logic                r_P1_Grant;
  logic [CONSEC_W-1:0] r_Consec;
  logic                r_Error;

  logic                w_Is_Idle;
  logic                w_Is_Rd0;
  logic                w_Is_Rd1;
  logic                w_Is_Wr1;
  logic                w_P0_Rd_Beat;
  logic                w_P1_Rd_Beat;
  logic                w_P1_Wr_Beat;
  logic                w_Beat;
  logic                w_Last;
  logic                w_Last_Beat;
  logic                w_P1_Turn;
  logic                w_Win_P0;
  logic                w_Win_P1;
  logic                w_Load;
  logic [ADDR_W-1:0]   w_Base_Addr;
  logic                w_Bad_Strobe;

  assign w_Is_Idle = (r_State == ST_IDLE);
  assign w_Is_Rd0  = (r_State == ST_RD0);
  assign w_Is_Rd1  = (r_State == ST_RD1);
  assign w_Is_Wr1  = (r_State == ST_WR1);

  // A controller strobe only counts as a beat in the state that expects it.
  assign w_P0_Rd_Beat = i_Data_Read_Valid & w_Is_Rd0;
  assign w_P1_Rd_Beat = i_Data_Read_Valid & w_Is_Rd1;
  assign w_P1_Wr_Beat = i_Data_Write_Done & w_Is_Wr1;
  assign w_Beat       = w_P0_Rd_Beat | w_P1_Rd_Beat | w_P1_Wr_Beat;
  assign w_Last_Beat  = w_Beat & w_Last;

  // Anti-starvation: after P0_MAX_CONSEC back-to-back P0 grants with P1
  // waiting, P1 takes the next slot. A limit of 0 means P0 always wins.
  assign w_P1_Turn = (P0_MAX_CONSEC != 0) && (r_Consec == CONSEC_MAX) && i_P1_Req;
  assign w_Win_P0  = w_Is_Idle & i_P0_Req & ~w_P1_Turn;
  assign w_Win_P1  = w_Is_Idle & i_P1_Req & ~w_Win_P0;
  assign w_Load    = w_Win_P0 | w_Win_P1;
  assign w_Base_Addr = w_Win_P0 ? i_P0_Addr : i_P1_Addr;

  assign w_Bad_Strobe = (i_Data_Read_Valid & ~(w_Is_Rd0 | w_Is_Rd1))
                      | (i_Data_Write_Done & ~w_Is_Wr1);

  sdram_port_arbiter_burst_beat_counter #(
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_beat_counter (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Load      (w_Load),
    .i_Base_Addr (w_Base_Addr),
    .i_Beat      (w_Beat),
    .o_Addr      (o_Data_Address),
    .o_Last      (w_Last)
  );

  // Arbitration FSM; command and grants are registered alongside the state so
  // they always agree with it.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State    <= ST_IDLE;
      r_Command  <= CMD_IDLE;
      r_P0_Grant <= 1'b0;
      r_P1_Grant <= 1'b0;
      r_Consec   <= '0;
      r_Error    <= 1'b0;
    end else begin
      if (w_Bad_Strobe) begin
        r_Error <= 1'b1;
      end

      case (r_State)
        ST_IDLE: begin
          if (w_Win_P0) begin
            r_State    <= ST_RD0;
            r_Command  <= CMD_READ;
            r_P0_Grant <= 1'b1;
            // Only grants taken while P1 is waiting count toward the limit.
            if (!i_P1_Req) begin
              r_Consec <= '0;
            end else if (r_Consec != CONSEC_MAX) begin
              r_Consec <= r_Consec + CONSEC_W'(1);
            end
          end else if (w_Win_P1) begin
            r_State    <= i_P1_Write ? ST_WR1 : ST_RD1;
            r_Command  <= i_P1_Write ? CMD_WRITE : CMD_READ;
            r_P1_Grant <= 1'b1;
            r_Consec   <= '0;
          end else begin
            r_Consec <= '0;
          end
        end

        default: begin
          // Burst in progress: leave on the final beat, which guarantees an
          // IDLE cycle before the next arbitration.
          if (w_Last_Beat) begin
            r_State    <= ST_IDLE;
            r_Command  <= CMD_IDLE;
            r_P0_Grant <= 1'b0;
            r_P1_Grant <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_Command       = r_Command;
  assign o_P0_Grant      = r_P0_Grant;
  assign o_P1_Grant      = r_P1_Grant;
  assign o_Error         = r_Error;

  assign o_P0_Data_Valid = w_P0_Rd_Beat;
  assign o_P0_Done       = w_P0_Rd_Beat & w_Last;
  assign o_P1_Data_Valid = w_P1_Rd_Beat;
  assign o_P1_Data_Next  = w_P1_Wr_Beat;
  assign o_P1_Done       = (w_P1_Rd_Beat | w_P1_Wr_Beat) & w_Last;

  // Write data goes straight through; P1 advances its word on Data_Next.
  assign o_Data_Write    = i_P1_Data;

endmodule
